// File: rtl/fc_argmax_if.sv
// ----------------------------------------------------------------------------
// fc_argmax_if
//   Groups the signals between the FC node bank, the argmax block and the
//   result consumer.
//
//   Handshake rules:
//     - Input side: a vector is taken on a rising edge where in_valid and
//       in_ready are both high. in_valid while in_ready is low is ignored.
//       The block does not buffer it.
//     - Output side: a result is handed over on a rising edge where
//       out_valid and out_ready are both high. class_idx and max_val stay
//       stable for as long as out_valid is high.
//
//   Signals:
//     in_valid   : node bank results valid (bank valid_out)
//     in_data    : M node results, node k at [k*DATA_WIDTH +: DATA_WIDTH]
//     in_ready   : block can accept a new vector
//     out_valid  : class_idx / max_val hold a result
//     out_ready  : consumer accepts the result
//     class_idx  : index of the largest node result
//     max_val    : bit-exact copy of the largest node result
//     busy       : high while scanning or holding a result
//
//   Modports:
//     slave  : the argmax block
//     master : the environment (node bank plus consumer)
// ----------------------------------------------------------------------------
interface fc_argmax_if #(
   parameter int DATA_WIDTH = 32,
   parameter int M          = 10,
   parameter int IDX_W      = 4
);
   logic                    in_valid;
   logic [M*DATA_WIDTH-1:0] in_data;
   logic                    in_ready;
   logic                    out_valid;
   logic                    out_ready;
   logic [IDX_W-1:0]        class_idx;
   logic [DATA_WIDTH-1:0]   max_val;
   logic                    busy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, class_idx, max_val, busy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, class_idx, max_val, busy
   );
endinterface

// File: rtl/fc_argmax.sv
// ----------------------------------------------------------------------------
// fc_argmax
//   Classification stage behind a bank of M fully-connected output nodes.
//   The block captures all M IEEE-754 single-precision results in one cycle.
//   It then scans them serially, one compare per cycle, and presents the
//   index and the bit-exact value of the largest result.
//
//   Ports:
//     CLK        : clock, all state changes on the rising edge
//     RST_N      : asynchronous active-low reset
//     bus        : fc_argmax_if.slave (in_valid/in_data/in_ready,
//                  out_valid/out_ready/class_idx/max_val, busy)
//     dbg_state  : current FSM state (0=IDLE, 1=SCAN, 2=DONE)
//
//   Ordering used by the scan:
//     - Sign-magnitude order. +0 and -0 compare equal.
//     - Infinities are ordered normally.
//     - Any NaN ranks below every non-NaN.
//     - Only a strictly greater element replaces the running best, so the
//       lowest index wins a tie. An all-NaN vector reports element 0.
// ----------------------------------------------------------------------------
module fc_argmax #(
   parameter int DATA_WIDTH = 32,
   parameter int M          = 10,
   parameter int IDX_W      = 4
) (
   input  logic       CLK,
   input  logic       RST_N,
   fc_argmax_if.slave bus,
   output logic [1:0] dbg_state
);

   localparam int EXP_W  = 8;
   localparam int MANT_W = DATA_WIDTH - 1 - EXP_W;
   localparam int VEC_W  = M * DATA_WIDTH;
   // One extra bit, so that an M of 2^IDX_W never wraps the counter.
   localparam int CNT_W  = IDX_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(M - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [VEC_W-1:0]      cap_q,   cap_d;
   logic [DATA_WIDTH-1:0] best_q,  best_d;
   logic [IDX_W-1:0]      idx_q,   idx_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic [DATA_WIDTH-1:0] scan_elem;

   function automatic logic is_nan(input logic [DATA_WIDTH-1:0] w);
      return (w[DATA_WIDTH-2 -: EXP_W] == {EXP_W{1'b1}}) &&
             (w[MANT_W-1:0] != '0);
   endfunction

   // Returns 1 when a is strictly greater than b in the scan ordering.
   function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-2:0] mag_a;
      logic [DATA_WIDTH-2:0] mag_b;
      logic                  sgn_a;
      logic                  sgn_b;
      logic                  res;
      mag_a = a[DATA_WIDTH-2:0];
      mag_b = b[DATA_WIDTH-2:0];
      sgn_a = a[DATA_WIDTH-1];
      sgn_b = b[DATA_WIDTH-1];
      res   = 1'b0;
      if (is_nan(a)) begin
         res = 1'b0;
      end else if (is_nan(b)) begin
         res = 1'b1;
      end else if ((mag_a == '0) && (mag_b == '0)) begin
         // +0 and -0 are equal. The sign is ignored here.
         res = 1'b0;
      end else if (!sgn_a && sgn_b) begin
         res = 1'b1;
      end else if (sgn_a && !sgn_b) begin
         res = 1'b0;
      end else if (!sgn_a) begin
         res = (mag_a > mag_b);
      end else begin
         // Both values are negative, so the smaller magnitude is the larger value.
         res = (mag_a < mag_b);
      end
      return res;
   endfunction

   // The element under compare this cycle. It is only used in SCAN, where
   // cnt_q is in the range 1..M-1.
   assign scan_elem = cap_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      best_d  = best_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               cap_d   = bus.in_data;
               best_d  = bus.in_data[DATA_WIDTH-1:0];
               idx_d   = '0;
               cnt_d   = CNT_W'(1);
               state_d = (M == 1) ? DONE : SCAN;
            end
         end
         SCAN: begin
            if (fp_gt(scan_elem, best_q)) begin
               best_d = scan_elem;
               idx_d  = cnt_q[IDX_W-1:0];
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cap_q   <= '0;
         best_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         best_q  <= best_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.class_idx = idx_q;
   assign bus.max_val   = best_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_fc_argmax.sv
// ----------------------------------------------------------------------------
// tb_fc_argmax
//   Directed bench for fc_argmax. It builds three instances: M=10, M=1 and
//   M=16. The drivers push the hand-computed {class_idx, max_val} expected
//   for each accepted vector into a queue per instance. A monitor per
//   instance pops the queue and compares on every out_valid & out_ready.
// ----------------------------------------------------------------------------
module tb_fc_argmax;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fc_argmax_if #(.DATA_WIDTH(32), .M(10), .IDX_W(4)) b10();
   fc_argmax_if #(.DATA_WIDTH(32), .M(1),  .IDX_W(4)) b1();
   fc_argmax_if #(.DATA_WIDTH(32), .M(16), .IDX_W(4)) b16();
   logic [1:0] st10, st1, st16;

   fc_argmax #(.DATA_WIDTH(32), .M(10), .IDX_W(4)) dut10 (
      .CLK(clk), .RST_N(rst_n), .bus(b10.slave), .dbg_state(st10));
   fc_argmax #(.DATA_WIDTH(32), .M(1), .IDX_W(4)) dut1 (
      .CLK(clk), .RST_N(rst_n), .bus(b1.slave), .dbg_state(st1));
   fc_argmax #(.DATA_WIDTH(32), .M(16), .IDX_W(4)) dut16 (
      .CLK(clk), .RST_N(rst_n), .bus(b16.slave), .dbg_state(st16));

   int total = 0;
   int bad   = 0;
   logic [35:0] exp_q[$];
   logic [35:0] exp1_q[$];
   logic [35:0] exp16_q[$];
   logic [35:0] e10, e1, e16;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: result presented with empty expected queue at %0t", name, $time);
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst_n && b10.out_valid && b10.out_ready) begin
         if (exp_q.size() == 0) unexpected("dut10 result");
         else begin
            e10 = exp_q.pop_front();
            chk("dut10 class_idx", 64'(b10.class_idx), 64'(e10[35:32]));
            chk("dut10 max_val", 64'(b10.max_val), 64'(e10[31:0]));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b1.out_valid && b1.out_ready) begin
         if (exp1_q.size() == 0) unexpected("dut1 result");
         else begin
            e1 = exp1_q.pop_front();
            chk("dut1 class_idx", 64'(b1.class_idx), 64'(e1[35:32]));
            chk("dut1 max_val", 64'(b1.max_val), 64'(e1[31:0]));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b16.out_valid && b16.out_ready) begin
         if (exp16_q.size() == 0) unexpected("dut16 result");
         else begin
            e16 = exp16_q.pop_front();
            chk("dut16 class_idx", 64'(b16.class_idx), 64'(e16[35:32]));
            chk("dut16 max_val", 64'(b16.max_val), 64'(e16[31:0]));
         end
      end
   end

   // ---------------- drivers (called 1ns after a rising edge) ----------------
   task automatic send10(input logic [319:0] v, input logic [3:0] ei, input logic [31:0] ev);
      int n;
      n = 0;
      while (!b10.in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!b10.in_ready) chk("dut10 in_ready wait timeout", 64'(b10.in_ready), 64'd1);
      b10.in_valid = 1'b1;
      b10.in_data  = v;
      exp_q.push_back({ei, ev});
      @(posedge clk); #1;
      b10.in_valid = 1'b0;
   endtask

   task automatic wait_out10(output int edges);
      edges = 1;
      while (!b10.out_valid && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic run10(input string name, input logic [319:0] v,
                        input logic [3:0] ei, input logic [31:0] ev);
      int edges;
      send10(v, ei, ev);
      wait_out10(edges);
      chk({name, " latency"}, 64'(edges), 64'd10);
      @(posedge clk); #1;
   endtask

   logic [319:0] vec;
   logic [319:0] v_ramp;
   logic [511:0] v16;
   int           edges;
   int           seen;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      b10.in_valid = 1'b0; b10.in_data = '0; b10.out_ready = 1'b1;
      b1.in_valid  = 1'b0; b1.in_data  = '0; b1.out_ready  = 1'b1;
      b16.in_valid = 1'b0; b16.in_data = '0; b16.out_ready = 1'b1;

      // ---- reset ----
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("reset in_ready", 64'(b10.in_ready), 64'd1);
      chk("reset out_valid", 64'(b10.out_valid), 64'd0);
      chk("reset busy", 64'(b10.busy), 64'd0);
      chk("reset class_idx", 64'(b10.class_idx), 64'd0);
      chk("reset max_val", 64'(b10.max_val), 64'd0);
      chk("reset state", 64'(st10), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // ---- float(k) ramp, held result ----
      v_ramp = {32'h41100000, 32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
                32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000, 32'h00000000};
      b10.out_ready = 1'b0;
      send10(v_ramp, 4'd9, 32'h41100000);
      chk("in_ready drops after capture", 64'(b10.in_ready), 64'd0);
      chk("busy in scan", 64'(b10.busy), 64'd1);
      wait_out10(edges);
      chk("ramp latency", 64'(edges), 64'd10);
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold out_valid", 64'(b10.out_valid), 64'd1);
         chk("hold class_idx", 64'(b10.class_idx), 64'd9);
         chk("hold max_val", 64'(b10.max_val), 64'h41100000);
      end
      b10.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("in_ready after accept", 64'(b10.in_ready), 64'd1);
      chk("out_valid after accept", 64'(b10.out_valid), 64'd0);

      // ---- ties ----
      vec = '0;
      vec[0*32 +: 32] = 32'hBF800000;
      vec[1*32 +: 32] = 32'h40400000;
      vec[2*32 +: 32] = 32'h40400000;
      vec[3*32 +: 32] = 32'hC0A00000;
      run10("tie", vec, 4'd1, 32'h40400000);

      // ---- signed zeros ----
      for (int k = 0; k < 10; k++) vec[k*32 +: 32] = 32'h80000000;
      vec[4*32 +: 32] = 32'h00000000;
      run10("zeros", vec, 4'd0, 32'h80000000);

      // ---- negatives and NaN ----
      for (int k = 0; k < 10; k++) vec[k*32 +: 32] = 32'hC0000000;
      vec[0*32 +: 32] = 32'h7FC00000;
      vec[2*32 +: 32] = 32'hBF000000;
      run10("neg nan", vec, 4'd2, 32'hBF000000);

      // ---- all NaN: element 0 bit-exact ----
      for (int k = 0; k < 10; k++) vec[k*32 +: 32] = 32'hFFC00000;
      vec[0*32 +: 32] = 32'h7FC00001;
      run10("all nan", vec, 4'd0, 32'h7FC00001);

      // ---- infinities and a NaN amid 1.0 ----
      for (int k = 0; k < 10; k++) vec[k*32 +: 32] = 32'h3F800000;
      vec[3*32 +: 32] = 32'hFF800000;
      vec[5*32 +: 32] = 32'h7F800001;
      vec[7*32 +: 32] = 32'h7F800000;
      run10("inf", vec, 4'd7, 32'h7F800000);

      // ---- back-pressure: extra in_valid during SCAN and DONE ----
      vec = '0;
      vec[0*32 +: 32] = 32'hBF800000;
      vec[1*32 +: 32] = 32'h40400000;
      vec[2*32 +: 32] = 32'h40400000;
      vec[3*32 +: 32] = 32'hC0A00000;
      b10.out_ready = 1'b0;
      send10(vec, 4'd1, 32'h40400000);
      repeat (2) @(posedge clk);
      #1;
      b10.in_valid = 1'b1;
      b10.in_data  = v_ramp;
      @(posedge clk); #1;
      b10.in_valid = 1'b0;
      chk("bp state in scan", 64'(st10), 64'd1);
      chk("bp in_ready in scan", 64'(b10.in_ready), 64'd0);
      wait_out10(edges);
      chk("bp out_valid reached", 64'(b10.out_valid), 64'd1);
      b10.in_valid = 1'b1;
      b10.in_data  = v_ramp;
      @(posedge clk); #1;
      b10.in_valid = 1'b0;
      chk("bp state in done", 64'(st10), 64'd2);
      chk("bp class_idx in done", 64'(b10.class_idx), 64'd1);
      b10.out_ready = 1'b1;
      @(posedge clk); #1;
      run10("bp second", v_ramp, 4'd9, 32'h41100000);

      // ---- reset during SCAN ----
      send10(v_ramp, 4'd9, 32'h41100000);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midscan rst in_ready", 64'(b10.in_ready), 64'd1);
      chk("midscan rst out_valid", 64'(b10.out_valid), 64'd0);
      chk("midscan rst busy", 64'(b10.busy), 64'd0);
      chk("midscan rst class_idx", 64'(b10.class_idx), 64'd0);
      chk("midscan rst max_val", 64'(b10.max_val), 64'd0);
      void'(exp_q.pop_back());
      @(posedge clk); #1 rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (b10.out_valid) seen++;
      end
      chk("no out_valid after reset", 64'(seen), 64'd0);
      for (int k = 0; k < 10; k++) vec[k*32 +: 32] = 32'hC0000000;
      vec[0*32 +: 32] = 32'h7FC00000;
      vec[2*32 +: 32] = 32'hBF000000;
      run10("after reset", vec, 4'd2, 32'hBF000000);

      // ---- M=1 instance ----
      b1.in_valid = 1'b1;
      b1.in_data  = 32'hC0A00000;
      exp1_q.push_back({4'd0, 32'hC0A00000});
      @(posedge clk); #1;
      b1.in_valid = 1'b0;
      chk("dut1 out_valid one edge", 64'(b1.out_valid), 64'd1);
      chk("dut1 class_idx", 64'(b1.class_idx), 64'd0);
      @(posedge clk); #1;
      chk("dut1 in_ready after accept", 64'(b1.in_ready), 64'd1);
      b1.in_valid = 1'b1;
      b1.in_data  = 32'h7FC00000;
      exp1_q.push_back({4'd0, 32'h7FC00000});
      @(posedge clk); #1;
      b1.in_valid = 1'b0;
      chk("dut1 nan out_valid", 64'(b1.out_valid), 64'd1);
      @(posedge clk); #1;

      // ---- M=16 instance, max at index 15 ----
      for (int k = 0; k < 16; k++) v16[k*32 +: 32] = 32'hBF800000;
      v16[15*32 +: 32] = 32'h3FC00000;
      b16.in_valid = 1'b1;
      b16.in_data  = v16;
      exp16_q.push_back({4'd15, 32'h3FC00000});
      @(posedge clk); #1;
      b16.in_valid = 1'b0;
      edges = 1;
      while (!b16.out_valid && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
      chk("dut16 latency", 64'(edges), 64'd16);
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      #1;
      chk("dut10 queue drained", 64'(exp_q.size()), 64'd0);
      chk("dut1 queue drained", 64'(exp1_q.size()), 64'd0);
      chk("dut16 queue drained", 64'(exp16_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
